alu_issue_stage: RTL and testbench

ALU_ISSUE_STAGE -- requirements
Module: alu_issue_stage

---
 rtl/alu_pkg.sv | 27 ++
 rtl/alu_decode.sv | 44 ++++
 rtl/alu_issue_stage.sv | 103 ++++++++++
 tb/tb_alu_issue_stage.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcode/FUNC3 constants and the ALU request record passed from decode to issue.
package alu_pkg;

    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM = 7'b0010011;

    typedef enum logic [2:0] {
        F3_ADD_SUB = 3'b000,
        F3_SLL     = 3'b001,
        F3_SLT     = 3'b010,
        F3_SLTU    = 3'b011,
        F3_XOR     = 3'b100,
        F3_SRL_SRA = 3'b101,
        F3_OR      = 3'b110,
        F3_AND     = 3'b111
    } alu_func3_e;

    typedef struct packed {
        logic [31:0] in0;
        logic [31:0] in1;
        logic [2:0]  func3;
        logic        sub;
        logic [4:0]  rd;
        logic        illegal;
    } alu_req_t;

endpackage

// File: rtl/alu_decode.sv
// Combinational RV32I OP / OP-IMM decode into an ALU request; other opcodes flag ILLEGAL.
module alu_decode
    import alu_pkg::*;
(
    input  logic [31:0] instr,
    input  logic [31:0] rs1_data,
    input  logic [31:0] rs2_data,
    output alu_req_t    req
);

    logic [6:0]  opcode;
    logic [2:0]  f3;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        is_shift;

    always_comb begin
        opcode   = instr[6:0];
        f3       = instr[14:12];
        // x0 always reads as zero, whatever the register file or bypass supplied
        op_a     = (instr[19:15] == 5'd0) ? '0 : rs1_data;
        op_b     = (instr[24:20] == 5'd0) ? '0 : rs2_data;
        is_shift = (f3 == F3_SLL) || (f3 == F3_SRL_SRA);

        req       = '0;
        req.func3 = f3;
        case (opcode)
            OPC_OP: begin
                req.in0 = op_a;
                req.in1 = op_b;
                req.sub = instr[30] & ((f3 == F3_ADD_SUB) || (f3 == F3_SRL_SRA));
                req.rd  = instr[11:7];
            end
            OPC_OPIMM: begin
                req.in0 = op_a;
                req.in1 = is_shift ? {27'd0, instr[24:20]} : {{20{instr[31]}}, instr[31:20]};
                req.sub = instr[30] & (f3 == F3_SRL_SRA);
                req.rd  = instr[11:7];
            end
            default: req.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_issue_stage.sv
// ALU issue stage: decode at acceptance into a 2-entry skid FIFO with registered IN_READY.
// Optional writeback bypass enabled by defining ALU_ISSUE_FORWARD_EN.
module alu_issue_stage
    import alu_pkg::*;
(
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        FLUSH,
    input  logic        IN_VALID,
    output logic        IN_READY,
    input  logic [31:0] INSTR,
    input  logic [31:0] RS1_DATA,
    input  logic [31:0] RS2_DATA,
    output logic        OUT_VALID,
    input  logic        OUT_READY,
    output logic [31:0] IN0,
    output logic [31:0] IN1,
    output logic [2:0]  FUNC3,
    output logic        SUB,
    output logic [4:0]  RD,
    output logic        ILLEGAL
`ifdef ALU_ISSUE_FORWARD_EN
    ,
    input  logic        WB_VALID,
    input  logic [4:0]  WB_RD,
    input  logic [31:0] WB_DATA
`endif
);

    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    alu_req_t    dec_req;
    alu_req_t    mem_q [2];
    alu_req_t    out_req;
    logic        wr_ptr_q;
    logic        rd_ptr_q;
    logic [1:0]  count_q;
    logic [1:0]  count_d;
    logic        in_ready_q;
    logic        push;
    logic        pop;

`ifdef ALU_ISSUE_FORWARD_EN
    always_comb begin
        rs1_val = RS1_DATA;
        rs2_val = RS2_DATA;
        if (WB_VALID && (WB_RD != 5'd0) && (WB_RD == INSTR[19:15])) rs1_val = WB_DATA;
        if (WB_VALID && (WB_RD != 5'd0) && (WB_RD == INSTR[24:20])) rs2_val = WB_DATA;
    end
`else
    assign rs1_val = RS1_DATA;
    assign rs2_val = RS2_DATA;
`endif

    alu_decode u_decode (
        .instr    (INSTR),
        .rs1_data (rs1_val),
        .rs2_data (rs2_val),
        .req      (dec_req)
    );

    // IN_READY comes from a flop, so a push never depends on this cycle's OUT_READY
    always_comb begin
        push    = IN_VALID & in_ready_q;
        pop     = OUT_VALID & OUT_READY;
        count_d = FLUSH ? 2'd0 : count_q + {1'b0, push} - {1'b0, pop};
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            count_q    <= '0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            in_ready_q <= 1'b0;
            for (int unsigned i = 0; i < 2; i++) mem_q[i] <= '0;
        end else begin
            count_q    <= count_d;
            in_ready_q <= (count_d != 2'd2);
            if (FLUSH) begin
                wr_ptr_q <= 1'b0;
                rd_ptr_q <= 1'b0;
            end else begin
                if (push) begin
                    mem_q[wr_ptr_q] <= dec_req;
                    wr_ptr_q        <= ~wr_ptr_q;
                end
                if (pop) rd_ptr_q <= ~rd_ptr_q;
            end
        end
    end

    assign OUT_VALID = (count_q != 2'd0);
    assign IN_READY  = in_ready_q;
    assign out_req   = OUT_VALID ? mem_q[rd_ptr_q] : '0;

    assign IN0     = out_req.in0;
    assign IN1     = out_req.in1;
    assign FUNC3   = out_req.func3;
    assign SUB     = out_req.sub;
    assign RD      = out_req.rd;
    assign ILLEGAL = out_req.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage: decode table, directed FIFO corner cases, random traffic vs a queue model.
module tb_alu_issue_stage;
    import alu_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] in0;
    logic [31:0] in1;
    logic [2:0]  func3;
    logic        sub;
    logic [4:0]  rd;
    logic        illegal;
`ifdef ALU_ISSUE_FORWARD_EN
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
`endif

    alu_issue_stage dut (
        .CLK       (clk),
        .RST_N     (rst_n),
        .FLUSH     (flush),
        .IN_VALID  (in_valid),
        .IN_READY  (in_ready),
        .INSTR     (instr),
        .RS1_DATA  (rs1_data),
        .RS2_DATA  (rs2_data),
        .OUT_VALID (out_valid),
        .OUT_READY (out_ready),
        .IN0       (in0),
        .IN1       (in1),
        .FUNC3     (func3),
        .SUB       (sub),
        .RD        (rd),
        .ILLEGAL   (illegal)
`ifdef ALU_ISSUE_FORWARD_EN
        ,
        .WB_VALID  (wb_valid),
        .WB_RD     (wb_rd),
        .WB_DATA   (wb_data)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [73:0] payload;
    assign payload = {in0, in1, func3, sub, rd, illegal};

    int n_tests = 0;
    int n_fail  = 0;

    alu_req_t mq[$];
    bit       m_ready;

    task automatic check(input string name, input logic [73:0] act, input logic [73:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] src_val(input logic [4:0] idx, input logic [31:0] rf);
        if (idx == 5'd0) return 32'd0;
`ifdef ALU_ISSUE_FORWARD_EN
        if (wb_valid && wb_rd == idx) return wb_data;
`endif
        return rf;
    endfunction

    function automatic alu_req_t ref_decode(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b);
        alu_req_t   r;
        logic [6:0] opc;
        logic [2:0] f;
        opc     = ins[6:0];
        f       = ins[14:12];
        r       = '0;
        r.func3 = f;
        if (opc == 7'h33) begin
            r.in0 = src_val(ins[19:15], a);
            r.in1 = src_val(ins[24:20], b);
            r.sub = ins[30] && (f == 3'd0 || f == 3'd5);
            r.rd  = ins[11:7];
        end else if (opc == 7'h13) begin
            r.in0 = src_val(ins[19:15], a);
            if (f == 3'd1 || f == 3'd5) r.in1 = 32'(ins[24:20]);
            else                        r.in1 = 32'($signed(ins[31:20]));
            r.sub = ins[30] && (f == 3'd5);
            r.rd  = ins[11:7];
        end else begin
            r.illegal = 1'b1;
        end
        return r;
    endfunction

    // One clock: advance the queue model with the inputs held across the edge, then compare.
    task automatic cycle();
        bit       push;
        bit       pop;
        alu_req_t nr;
        push = in_valid && m_ready;
        pop  = (mq.size() != 0) && out_ready;
        nr   = ref_decode(instr, rs1_data, rs2_data);
        @(posedge clk);
        if (flush) mq.delete();
        else begin
            if (pop) void'(mq.pop_front());
            if (push) mq.push_back(nr);
        end
        m_ready = (mq.size() < 2);
        #1;
        check("out_valid", 74'(out_valid), 74'(mq.size() != 0));
        check("in_ready", 74'(in_ready), 74'(m_ready));
        if (mq.size() != 0) check("payload", payload, mq[0]);
    endtask

    task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b);
        in_valid = v;
        instr    = ins;
        rs1_data = a;
        rs2_data = b;
    endtask

    typedef struct {
        logic [31:0] ins;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] e_in0;
        logic [31:0] e_in1;
        logic [2:0]  e_f3;
        logic        e_sub;
        logic [4:0]  e_rd;
        logic        e_ill;
    } vec_t;

    vec_t vecs[10];

    initial begin
        vecs[0] = '{32'h002081B3, 32'd5,          32'd7,          32'd5,          32'd7,          3'd0, 1'b0, 5'd3, 1'b0};
        vecs[1] = '{32'h4030D113, 32'h80000000,   32'd1,          32'h80000000,   32'd3,          3'd5, 1'b1, 5'd2, 1'b0};
        vecs[2] = '{32'hFFF08213, 32'd10,         32'd99,         32'd10,         32'hFFFFFFFF,   3'd0, 1'b0, 5'd4, 1'b0};
        vecs[3] = '{32'h402082B3, 32'd9,          32'd4,          32'd9,          32'd4,          3'd0, 1'b1, 5'd5, 1'b0};
        vecs[4] = '{32'h4020F2B3, 32'hF0F0F0F0,   32'h0F0F0F0F,   32'hF0F0F0F0,   32'h0F0F0F0F,   3'd7, 1'b0, 5'd5, 1'b0};
        vecs[5] = '{32'h00000333, 32'hAAAA,       32'hBBBB,       32'd0,          32'd0,          3'd0, 1'b0, 5'd6, 1'b0};
        vecs[6] = '{32'h0040A183, 32'd123,        32'd456,        32'd0,          32'd0,          3'd2, 1'b0, 5'd0, 1'b1};
        vecs[7] = '{32'h80509393, 32'h1234,       32'd8,          32'h1234,       32'd5,          3'd1, 1'b0, 5'd7, 1'b0};
        vecs[8] = '{32'h12316413, 32'h55,         32'd1,          32'h55,         32'h123,        3'd6, 1'b0, 5'd8, 1'b0};
        vecs[9] = '{32'h4020D4B3, 32'd100,        32'd3,          32'd100,        32'd3,          3'd5, 1'b1, 5'd9, 1'b0};

        rst_n     = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;
        drive(1'b0, 32'd0, 32'd0, 32'd0);
`ifdef ALU_ISSUE_FORWARD_EN
        wb_valid = 1'b0;
        wb_rd    = 5'd0;
        wb_data  = 32'd0;
`endif
        m_ready = 1'b0;

        // Reset state, then first cycle after release
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 74'(out_valid), 74'd0);
        check("rst_in_ready", 74'(in_ready), 74'd0);
        check("rst_payload", payload, 74'd0);
        rst_n = 1'b1;
        cycle();
        check("first_ready", 74'(in_ready), 74'd1);

        // Decode table, one instruction at a time through an empty stage
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, vecs[i].ins, vecs[i].a, vecs[i].b);
            cycle();
            check($sformatf("vec%0d", i), payload,
                  {vecs[i].e_in0, vecs[i].e_in1, vecs[i].e_f3, vecs[i].e_sub, vecs[i].e_rd, vecs[i].e_ill});
            check($sformatf("vec%0d_valid", i), 74'(out_valid), 74'd1);
            drive(1'b0, 32'd0, 32'd0, 32'd0);
            cycle();
        end

        // Backpressure: three pushes, only two fit
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 32'h002081B3, 32'(11 * (k + 1)), 32'd1);
            cycle();
        end
        check("bp_ready", 74'(in_ready), 74'd0);
        check("bp_head", 74'(in0), 74'd11);
        drive(1'b0, 32'd0, 32'd0, 32'd0);
        out_ready = 1'b1;
        cycle();
        check("bp_second", 74'(in0), 74'd22);
        cycle();
        check("bp_empty", 74'(out_valid), 74'd0);

        // Push+pop when full, then push+pop with one entry
        out_ready = 1'b0;
        drive(1'b1, 32'h002081B3, 32'd44, 32'd1); cycle();
        drive(1'b1, 32'h002081B3, 32'd55, 32'd1); cycle();
        out_ready = 1'b1;
        drive(1'b1, 32'h002081B3, 32'd66, 32'd1); cycle();
        check("full_pp_head", 74'(in0), 74'd55);
        check("full_pp_ready", 74'(in_ready), 74'd1);
        drive(1'b1, 32'h002081B3, 32'd77, 32'd1); cycle();
        check("one_pp_head", 74'(in0), 74'd77);
        drive(1'b0, 32'd0, 32'd0, 32'd0);
        cycle();

        // Flush with two entries and a concurrent push
        out_ready = 1'b0;
        drive(1'b1, 32'h002081B3, 32'd88, 32'd1); cycle();
        drive(1'b1, 32'h002081B3, 32'd99, 32'd1); cycle();
        flush = 1'b1;
        drive(1'b1, 32'h002081B3, 32'd111, 32'd1); cycle();
        check("flush_valid", 74'(out_valid), 74'd0);
        check("flush_ready", 74'(in_ready), 74'd1);
        flush = 1'b0;
        drive(1'b0, 32'd0, 32'd0, 32'd0);
        out_ready = 1'b1;
        repeat (2) begin
            cycle();
            check("flush_stale", 74'(out_valid), 74'd0);
        end

        // Flush with one entry while a push is accepted: the push is dropped
        drive(1'b1, 32'h002081B3, 32'd5, 32'd1);
        out_ready = 1'b0;
        cycle();
        flush = 1'b1;
        cycle();
        check("flush1_valid", 74'(out_valid), 74'd0);
        flush = 1'b0;
        drive(1'b0, 32'd0, 32'd0, 32'd0);
        cycle();
        check("flush1_stale", 74'(out_valid), 74'd0);

`ifdef ALU_ISSUE_FORWARD_EN
        out_ready = 1'b1;
        wb_valid  = 1'b1;
        wb_rd     = 5'd1;
        wb_data   = 32'hDEAD;
        drive(1'b1, 32'h002081B3, 32'd5, 32'd7); cycle();
        check("fwd_x1", 74'(in0), 74'hDEAD);
        drive(1'b1, 32'h00200133, 32'd5, 32'd7); cycle();
        check("fwd_x0", 74'(in0), 74'd0);
        wb_valid = 1'b0;
        drive(1'b0, 32'd0, 32'd0, 32'd0);
        cycle();
`endif

        // Reset mid-stream with two entries buffered
        out_ready = 1'b0;
        drive(1'b1, 32'h002081B3, 32'd1, 32'd2); cycle();
        drive(1'b1, 32'h002081B3, 32'd3, 32'd4); cycle();
        drive(1'b0, 32'd0, 32'd0, 32'd0);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 74'(out_valid), 74'd0);
        check("mid_rst_ready", 74'(in_ready), 74'd0);
        check("mid_rst_payload", payload, 74'd0);
        mq.delete();
        m_ready = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cycle();
        check("mid_rst_first_ready", 74'(in_ready), 74'd1);

        // Random traffic against the queue model
        for (int c = 0; c < 600; c++) begin
            logic [31:0] ins;
            ins = $urandom;
            case ($urandom_range(0, 3))
                0: ins[6:0] = 7'h33;
                1, 2: ins[6:0] = 7'h13;
                default: ;
            endcase
            drive(1'($urandom_range(0, 3) != 0), ins, $urandom, $urandom);
            out_ready = 1'($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 19) == 0);
`ifdef ALU_ISSUE_FORWARD_EN
            wb_valid = 1'($urandom);
            wb_rd    = 5'($urandom_range(0, 3));
            wb_data  = $urandom;
`endif
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
